serial_fifo_drain_arbiter: RTL

Round-robin drain controller for the eight per-channel receive FIFOs in the multi_serial_x8 bridge. Picks a non-empty channel FIFO, reads a bounded burst one byte at a time, and emits it to the single host-bound byte stream as a framed packet: sync byte, channel ID, length, payload. Sits between the channel FIFO bank and the host UART TX; it is the only agent driving FIFO read enables on this side.

---
 rtl/serial_bridge_pkg.sv | 23 ++
 rtl/rr_priority_pick.sv | 29 ++
 rtl/serial_fifo_drain_arbiter.sv | 122 ++++++++++++
 3 files changed

// File: rtl/serial_bridge_pkg.sv
// Shared constants for the multi_serial_x8 bridge: drain FSM encoding and
// host frame layout (sync, channel, length, payload).
package serial_bridge_pkg;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_HDR_SYNC = 3'd1;
  localparam logic [2:0] ST_HDR_CH   = 3'd2;
  localparam logic [2:0] ST_HDR_LEN  = 3'd3;
  localparam logic [2:0] ST_RD_REQ   = 3'd4;
  localparam logic [2:0] ST_RD_WAIT  = 3'd5;
  localparam logic [2:0] ST_PAY      = 3'd6;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;

  localparam int FRAME_HDR_BYTES = 3;

  // Byte offsets within a frame, as seen by the host-side decoder.
  localparam int OFF_SYNC = 0;
  localparam int OFF_CH   = 1;
  localparam int OFF_LEN  = 2;
  localparam int OFF_PAY  = 3;

endpackage

// File: rtl/rr_priority_pick.sv
// Combinational round-robin picker: first set req bit searching upward
// from last+1, wrapping modulo N_CH (N_CH a power of two).
module rr_priority_pick #(
  parameter int N_CH = 8
) (
  input  logic [N_CH-1:0]         req,
  input  logic [$clog2(N_CH)-1:0] last,
  output logic [$clog2(N_CH)-1:0] gnt_idx,
  output logic                    gnt_any
);
  localparam int IDX_W = $clog2(N_CH);

  logic [IDX_W-1:0] idx;

  // Walk from farthest to nearest so the closest requester wins.
  always_comb begin
    gnt_idx = last;
    gnt_any = 1'b0;
    idx     = last;
    for (int k = N_CH; k >= 1; k--) begin
      idx = last + IDX_W'(k);
      if (req[idx]) begin
        gnt_idx = idx;
        gnt_any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/serial_fifo_drain_arbiter.sv
// Round-robin drain of the per-channel RX FIFOs into one framed host byte
// stream: SYNC, channel, length, then a bounded payload burst.
module serial_fifo_drain_arbiter #(
  parameter int         N_CH      = 8,
  parameter int         DATA_W    = 8,
  parameter int         FILL_W    = 9,
  parameter int         MAX_BURST = 64,
  parameter logic [7:0] SYNC_BYTE = serial_bridge_pkg::SYNC_BYTE,
  parameter int         RD_LAT    = 2
) (
  input  logic                      clk,
  input  logic                      clr,
  input  logic                      en,
  input  logic [N_CH-1:0]           ch_empty,
  input  logic [N_CH*FILL_W-1:0]    ch_fill_ct,
  output logic [N_CH-1:0]           ch_rd_en,
  input  logic [N_CH*DATA_W-1:0]    ch_rd_data,
  output logic [DATA_W-1:0]         tx_data,
  output logic                      tx_valid,
  input  logic                      tx_ready,
  output logic                      busy,
  output logic [$clog2(N_CH)-1:0]   cur_ch
);
  import serial_bridge_pkg::*;

  localparam int IDX_W = $clog2(N_CH);

  logic [2:0]        state;
  logic [IDX_W-1:0]  last_grant;
  logic [IDX_W-1:0]  gnt_idx;
  logic              gnt_any;
  logic [7:0]        rem;
  logic [7:0]        len_pick;
  logic [FILL_W-1:0] fill_sel;
  logic [DATA_W-1:0] rd_byte;
  logic [RD_LAT:0]   vld_pipe;
  logic              hs;
  logic              issue_rd;

  rr_priority_pick #(.N_CH(N_CH)) u_pick (
    .req     (~ch_empty),
    .last    (last_grant),
    .gnt_idx (gnt_idx),
    .gnt_any (gnt_any)
  );

  always_comb begin
    fill_sel = ch_fill_ct[gnt_idx*FILL_W +: FILL_W];
    len_pick = (32'(fill_sel) > 32'(MAX_BURST)) ? 8'(MAX_BURST) : 8'(fill_sel);
  end

  assign rd_byte  = ch_rd_data[cur_ch*DATA_W +: DATA_W];
  assign hs       = tx_valid && tx_ready;
  // A read is launched on the handshake that leads into RD_REQ, so the
  // strobe is registered and lands exactly in the RD_REQ cycle.
  assign issue_rd = hs && ((state == ST_HDR_LEN) || (state == ST_PAY && rem != 8'd1));

  always_ff @(posedge clk) begin
    if (clr) begin
      state      <= ST_IDLE;
      last_grant <= IDX_W'(N_CH-1);
      cur_ch     <= '0;
      rem        <= '0;
      tx_data    <= '0;
      tx_valid   <= 1'b0;
      ch_rd_en   <= '0;
      busy       <= 1'b0;
      vld_pipe   <= '0;
    end else begin
      ch_rd_en <= issue_rd ? (N_CH'(1) << cur_ch) : '0;
      vld_pipe <= {vld_pipe[RD_LAT-1:0], issue_rd};
      case (state)
        ST_IDLE: begin
          // A non-empty flag with zero fill is skipped without moving the pointer.
          if (en && gnt_any && len_pick != 8'd0) begin
            cur_ch     <= gnt_idx;
            last_grant <= gnt_idx;
            rem        <= len_pick;
            tx_data    <= DATA_W'(SYNC_BYTE);
            tx_valid   <= 1'b1;
            busy       <= 1'b1;
            state      <= ST_HDR_SYNC;
          end
        end
        ST_HDR_SYNC: if (hs) begin
          tx_data <= DATA_W'(cur_ch);
          state   <= ST_HDR_CH;
        end
        ST_HDR_CH: if (hs) begin
          tx_data <= DATA_W'(rem);
          state   <= ST_HDR_LEN;
        end
        ST_HDR_LEN: if (hs) begin
          tx_valid <= 1'b0;
          state    <= ST_RD_REQ;
        end
        ST_RD_REQ: state <= ST_RD_WAIT;
        ST_RD_WAIT: if (vld_pipe[RD_LAT]) begin
          tx_data  <= rd_byte;
          tx_valid <= 1'b1;
          state    <= ST_PAY;
        end
        ST_PAY: if (hs) begin
          tx_valid <= 1'b0;
          rem      <= rem - 8'd1;
          if (rem == 8'd1) begin
            busy  <= 1'b0;
            state <= ST_IDLE;
          end else begin
            state <= ST_RD_REQ;
          end
        end
        default: begin
          tx_valid <= 1'b0;
          busy     <= 1'b0;
          state    <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
